wb_mux_wd: RTL and testbench

WB_MUX_WD -- requirements
Module: wb_mux_wd

---
 rtl/wb_intercon_pkg.sv | 18 +
 rtl/wb_addr_dec.sv | 32 +++
 rtl/wb_mux_wd.sv | 172 +++++++++++++++++
 tb/tb_wb_mux_wd.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_intercon_pkg.sv
// Shared definitions for the Wishbone interconnect blocks: mux FSM state
// encoding and the Wishbone CTI/BTE cycle-type constants.
package wb_intercon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY     = 2'd1,
        ST_UNMAPPED = 2'd2,
        ST_TOUT     = 2'd3
    } wb_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_addr_dec.sv
// Address decoder: compares the master address against every slave's
// base/mask pair and reports the lowest-numbered match.
module wb_addr_dec #(
    parameter int                       num_slaves = 2,
    parameter int                       aw         = 32,
    parameter logic [num_slaves*aw-1:0] MATCH_ADDR = '0,
    parameter logic [num_slaves*aw-1:0] MATCH_MASK = '0,
    parameter int                       IW         = (num_slaves > 1) ? $clog2(num_slaves) : 1
) (
    input  logic [aw-1:0]         i_adr,
    output logic [num_slaves-1:0] o_match,
    output logic [IW-1:0]         o_idx,
    output logic                  o_hit
);

    // Scanning from the top down lets the lowest matching slave overwrite the rest.
    always_comb begin
        o_match = '0;
        o_idx   = '0;
        o_hit   = 1'b0;
        for (int i = num_slaves - 1; i >= 0; i--) begin
            if ((i_adr & MATCH_MASK[i*aw +: aw]) ==
                (MATCH_ADDR[i*aw +: aw] & MATCH_MASK[i*aw +: aw])) begin
                o_match    = '0;
                o_match[i] = 1'b1;
                o_idx      = IW'(i);
                o_hit      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_mux_wd.sv
// Wishbone 1:N mux with address decode, unmapped-access error response and
// a per-strobe watchdog that terminates stalled slave accesses with an error.
module wb_mux_wd
    import wb_intercon_pkg::*;
#(
    parameter int                       dw         = 32,
    parameter int                       aw         = 32,
    parameter int                       num_slaves = 2,
    parameter logic [num_slaves*aw-1:0] MATCH_ADDR = '0,
    parameter logic [num_slaves*aw-1:0] MATCH_MASK = '0,
    parameter int                       TIMEOUT    = 255
) (
    input  logic                     wb_clk,
    input  logic                     wb_rst_n,
    input  logic [aw-1:0]            wbm_adr_i,
    input  logic [dw-1:0]            wbm_dat_i,
    input  logic [dw/8-1:0]          wbm_sel_i,
    input  logic                     wbm_we_i,
    input  logic                     wbm_cyc_i,
    input  logic                     wbm_stb_i,
    input  logic [2:0]               wbm_cti_i,
    input  logic [1:0]               wbm_bte_i,
    output logic [dw-1:0]            wbm_sdt_o,
    output logic                     wbm_ack_o,
    output logic                     wbm_err_o,
    output logic                     wbm_rty_o,
    output logic [aw-1:0]            wbs_adr_o,
    output logic [dw-1:0]            wbs_dat_o,
    output logic [dw/8-1:0]          wbs_sel_o,
    output logic                     wbs_we_o,
    output logic [num_slaves-1:0]    wbs_cyc_o,
    output logic                     wbs_stb_o,
    output logic [2:0]               wbs_cti_o,
    output logic [1:0]               wbs_bte_o,
    input  logic [num_slaves*dw-1:0] wbs_sdt_i,
    input  logic [num_slaves-1:0]    wbs_ack_i,
    input  logic [num_slaves-1:0]    wbs_err_i,
    input  logic [num_slaves-1:0]    wbs_rty_i,
    output logic                     timeout_o,
    output logic [aw-1:0]            err_adr_o
);

    localparam int              IW         = (num_slaves > 1) ? $clog2(num_slaves) : 1;
    localparam int              CW         = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   L_CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]   L_CNT_MAX  = CW'(TIMEOUT);

    wb_state_e             r_state;
    wb_state_e             w_next;
    logic [IW-1:0]         r_idx;
    logic [num_slaves-1:0] r_sel;
    logic [CW-1:0]         r_cnt;
    logic [aw-1:0]         r_err_adr;
    logic                  r_timeout;

    logic [IW-1:0]         w_dec_idx;
    logic [num_slaves-1:0] w_dec_match;
    logic                  w_dec_hit;
    logic                  w_req;
    logic                  w_busy;
    logic [dw-1:0]         w_sel_dat;
    logic                  w_sel_ack;
    logic                  w_sel_err;
    logic                  w_sel_rty;
    logic                  w_resp;

    wb_addr_dec #(
        .num_slaves (num_slaves),
        .aw         (aw),
        .MATCH_ADDR (MATCH_ADDR),
        .MATCH_MASK (MATCH_MASK),
        .IW         (IW)
    ) u_dec (
        .i_adr   (wbm_adr_i),
        .o_match (w_dec_match),
        .o_idx   (w_dec_idx),
        .o_hit   (w_dec_hit)
    );

    assign w_req  = wbm_cyc_i & wbm_stb_i;
    assign w_busy = (r_state == ST_BUSY);

    // Broadcast paths are forced low while reset is held so no stale request leaks out.
    assign wbs_adr_o = wb_rst_n ? wbm_adr_i : '0;
    assign wbs_dat_o = wb_rst_n ? wbm_dat_i : '0;
    assign wbs_sel_o = wb_rst_n ? wbm_sel_i : '0;
    assign wbs_we_o  = wb_rst_n ? wbm_we_i  : 1'b0;
    assign wbs_cti_o = wb_rst_n ? wbm_cti_i : CTI_CLASSIC;
    assign wbs_bte_o = wb_rst_n ? wbm_bte_i : BTE_LINEAR;

    always_comb begin
        w_sel_dat = '0;
        w_sel_ack = 1'b0;
        w_sel_err = 1'b0;
        w_sel_rty = 1'b0;
        for (int i = 0; i < num_slaves; i++) begin
            if (r_idx == IW'(i)) begin
                w_sel_dat = wbs_sdt_i[i*dw +: dw];
                w_sel_ack = wbs_ack_i[i];
                w_sel_err = wbs_err_i[i];
                w_sel_rty = wbs_rty_i[i];
            end
        end
    end

    assign w_resp = w_sel_ack | w_sel_err | w_sel_rty;

    always_comb begin
        w_next    = r_state;
        wbs_cyc_o = '0;
        wbs_stb_o = 1'b0;
        wbm_sdt_o = '0;
        wbm_ack_o = 1'b0;
        wbm_err_o = 1'b0;
        wbm_rty_o = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) w_next = w_dec_hit ? ST_BUSY : ST_UNMAPPED;
            end
            ST_BUSY: begin
                wbs_cyc_o = wbm_cyc_i ? r_sel : '0;
                wbs_stb_o = wbm_stb_i;
                wbm_sdt_o = w_sel_dat;
                wbm_ack_o = w_sel_ack;
                wbm_err_o = w_sel_err;
                wbm_rty_o = w_sel_rty;
                if (!wbm_cyc_i)
                    w_next = ST_IDLE;
                else if (wbm_stb_i && !w_resp && r_cnt == L_CNT_LAST)
                    w_next = ST_TOUT;
            end
            ST_UNMAPPED, ST_TOUT: begin
                wbm_err_o = 1'b1;
                w_next    = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) r_state <= ST_IDLE;
        else           r_state <= w_next;
    end

    // The watchdog restarts on every response or idle strobe and saturates rather than wrapping.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_idx     <= '0;
            r_sel     <= '0;
            r_cnt     <= '0;
            r_err_adr <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= (w_next == ST_TOUT);
            if (r_state == ST_IDLE && w_req) begin
                r_idx <= w_dec_idx;
                r_sel <= w_dec_match;
            end
            if ((r_state == ST_IDLE && w_req && !w_dec_hit) ||
                (w_busy && w_next == ST_TOUT))
                r_err_adr <= wbm_adr_i;
            if (w_busy && wbm_stb_i && !w_resp)
                r_cnt <= (r_cnt == L_CNT_MAX) ? r_cnt : r_cnt + 1'b1;
            else
                r_cnt <= '0;
        end
    end

    assign timeout_o = r_timeout;
    assign err_adr_o = r_err_adr;

endmodule

// File: tb/tb_wb_mux_wd.sv
// Self-checking bench for wb_mux_wd: three slaves on 256 MB windows, a
// 16-cycle watchdog, table-driven transfers scored through an expect queue.
module tb_wb_mux_wd;
    import wb_intercon_pkg::*;

    localparam int NS   = 3;
    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int TOUT = 16;
    localparam logic [NS*AW-1:0] P_ADDR = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [NS*AW-1:0] P_MASK = {3{32'hF000_0000}};

    logic              wb_clk = 1'b0;
    logic              wb_rst_n;
    logic [AW-1:0]     wbm_adr_i;
    logic [DW-1:0]     wbm_dat_i;
    logic [DW/8-1:0]   wbm_sel_i;
    logic              wbm_we_i, wbm_cyc_i, wbm_stb_i;
    logic [2:0]        wbm_cti_i;
    logic [1:0]        wbm_bte_i;
    logic [DW-1:0]     wbm_sdt_o;
    logic              wbm_ack_o, wbm_err_o, wbm_rty_o;
    logic [AW-1:0]     wbs_adr_o;
    logic [DW-1:0]     wbs_dat_o;
    logic [DW/8-1:0]   wbs_sel_o;
    logic              wbs_we_o;
    logic [NS-1:0]     wbs_cyc_o;
    logic              wbs_stb_o;
    logic [2:0]        wbs_cti_o;
    logic [1:0]        wbs_bte_o;
    logic [NS*DW-1:0]  wbs_sdt_i;
    logic [NS-1:0]     wbs_ack_i, wbs_err_i, wbs_rty_i;
    logic              timeout_o;
    logic [AW-1:0]     err_adr_o;

    always #5 wb_clk = ~wb_clk;

    wb_mux_wd #(
        .dw (DW), .aw (AW), .num_slaves (NS),
        .MATCH_ADDR (P_ADDR), .MATCH_MASK (P_MASK), .TIMEOUT (TOUT)
    ) dut (
        .wb_clk (wb_clk), .wb_rst_n (wb_rst_n),
        .wbm_adr_i (wbm_adr_i), .wbm_dat_i (wbm_dat_i), .wbm_sel_i (wbm_sel_i),
        .wbm_we_i (wbm_we_i), .wbm_cyc_i (wbm_cyc_i), .wbm_stb_i (wbm_stb_i),
        .wbm_cti_i (wbm_cti_i), .wbm_bte_i (wbm_bte_i),
        .wbm_sdt_o (wbm_sdt_o), .wbm_ack_o (wbm_ack_o), .wbm_err_o (wbm_err_o),
        .wbm_rty_o (wbm_rty_o),
        .wbs_adr_o (wbs_adr_o), .wbs_dat_o (wbs_dat_o), .wbs_sel_o (wbs_sel_o),
        .wbs_we_o (wbs_we_o), .wbs_cyc_o (wbs_cyc_o), .wbs_stb_o (wbs_stb_o),
        .wbs_cti_o (wbs_cti_o), .wbs_bte_o (wbs_bte_o),
        .wbs_sdt_i (wbs_sdt_i), .wbs_ack_i (wbs_ack_i), .wbs_err_i (wbs_err_i),
        .wbs_rty_i (wbs_rty_i),
        .timeout_o (timeout_o), .err_adr_o (err_adr_o)
    );

    // kind: 0 = slave ack, 1 = unmapped error, 2 = watchdog timeout
    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
        int          delay;
        int          beats;
        logic [2:0]  expCyc;
        int          kind;
    } vec_t;

    typedef struct {
        int          kind;
        logic [31:0] data;
        int          cycleNo;
        logic [31:0] errAdr;
    } exp_t;

    exp_t sbQ[$];
    vec_t vecs[9];
    int   checkCount = 0;
    int   errCount   = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checkCount++;
        if (act !== expv) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic driveSlaves(input int tgt, input logic ack, input logic [31:0] d);
        wbs_ack_i = '0;
        if (ack) wbs_ack_i[tgt] = 1'b1;
        for (int i = 0; i < NS; i++)
            wbs_sdt_i[i*DW +: DW] = (i == tgt) ? d : ~d;
    endtask

    // Acts as master and as the addressed slave; slave responses are timed in
    // cycles after the strobe's first (decode) cycle, which is cycle 0.
    task automatic applyStimulus(input vec_t v);
        int          tgt;
        int          cycle;
        int          beatsSeen;
        bit          lastResp;
        bit          done;
        exp_t        e;
        logic [3:0]  expFlags;
        tgt = v.expCyc[1] ? 1 : (v.expCyc[2] ? 2 : 0);
        for (int b = 0; b < ((v.kind == 0) ? v.beats : 1); b++) begin
            e.kind    = v.kind;
            e.data    = (v.kind == 0) ? v.dat + 32'(b) : 32'h0;
            e.cycleNo = (v.kind == 0) ? v.delay + b : ((v.kind == 1) ? 1 : TOUT + 1);
            e.errAdr  = (v.kind == 0) ? 32'h0 : v.adr;
            sbQ.push_back(e);
        end
        @(posedge wb_clk); #1;
        wbm_adr_i = v.adr;
        wbm_we_i  = v.we;
        wbm_dat_i = ~v.adr;
        wbm_sel_i = 4'hF;
        wbm_cti_i = (v.beats > 1) ? CTI_INCR : CTI_CLASSIC;
        wbm_bte_i = 2'b00;
        wbm_cyc_i = 1'b1;
        wbm_stb_i = 1'b1;
        driveSlaves(tgt, 1'b0, 32'h0);
        cycle = 0; beatsSeen = 0; lastResp = 0; done = 0;
        while (!done && cycle < 64) begin
            @(negedge wb_clk);
            if (cycle >= 1) begin
                if (v.kind == 1)
                    checkOutput("unmapped_no_cyc", 32'(wbs_cyc_o), 32'h0);
                else if (v.kind == 0 || cycle <= TOUT)
                    checkOutput("cyc_select", 32'(wbs_cyc_o), 32'(v.expCyc));
            end
            if (wbm_ack_o || wbm_err_o || wbm_rty_o) begin
                if (sbQ.size() == 0) begin
                    checkCount++; errCount++;
                    $display("[TB] FAIL unexpected_resp: got a response at cycle %0d, expected none", cycle);
                    lastResp = 1;
                end else begin
                    e = sbQ.pop_front();
                    expFlags = (e.kind == 0) ? 4'b1000 : ((e.kind == 1) ? 4'b0100 : 4'b0101);
                    checkOutput("resp_flags", 32'({wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o}), 32'(expFlags));
                    checkOutput("resp_cycle", 32'(cycle), 32'(e.cycleNo));
                    if (e.kind == 0) begin
                        if (!v.we) checkOutput("read_data", wbm_sdt_o, e.data);
                        checkOutput("bcast_adr", wbs_adr_o, v.adr);
                        checkOutput("bcast_we", 32'(wbs_we_o), 32'(v.we));
                    end else begin
                        checkOutput("err_adr", err_adr_o, e.errAdr);
                        checkOutput("err_no_cyc", 32'(wbs_cyc_o), 32'h0);
                    end
                    beatsSeen++;
                    if (e.kind != 0 || beatsSeen == v.beats) lastResp = 1;
                end
            end
            @(posedge wb_clk); #1;
            cycle++;
            if (lastResp) begin
                done = 1;
            end else begin
                if (v.kind == 0 && cycle >= v.delay && cycle < v.delay + v.beats)
                    driveSlaves(tgt, 1'b1, v.dat + 32'(cycle - v.delay));
                else
                    driveSlaves(tgt, 1'b0, 32'h0);
                if (v.beats > 1 && beatsSeen == v.beats - 1) wbm_cti_i = CTI_EOB;
            end
        end
        if (!done) begin
            checkCount++; errCount++;
            $display("[TB] FAIL response_wait: got no response in %0d cycles, expected one", cycle);
        end
        wbm_cyc_i = 1'b0;
        wbm_stb_i = 1'b0;
        wbm_cti_i = CTI_CLASSIC;
        driveSlaves(tgt, 1'b0, 32'h0);
        @(negedge wb_clk);
        checkOutput("post_cyc_drop", 32'(wbs_cyc_o), 32'h0);
        checkOutput("post_no_tout", 32'(timeout_o), 32'h0);
        checkOutput("post_no_resp", 32'({wbm_ack_o, wbm_err_o, wbm_rty_o}), 32'h0);
        @(posedge wb_clk); #1;
        driveSlaves(tgt, 1'b0, 32'hDEAD_BEEF);
        @(negedge wb_clk);
        checkOutput("idle_sdt_zero", wbm_sdt_o, 32'h0);
        driveSlaves(tgt, 1'b0, 32'h0);
    endtask

    initial begin
        wb_rst_n  = 1'b1;
        wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0; wbm_we_i = 1'b0;
        wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0; wbm_cti_i = '0; wbm_bte_i = '0;
        wbs_sdt_i = '0; wbs_ack_i = '0; wbs_err_i = '0; wbs_rty_i = '0;

        vecs[0] = '{32'h1000_0004, 1'b0, 32'hCAFE_F00D, 1,  1, 3'b010, 0};
        vecs[1] = '{32'h0000_0100, 1'b1, 32'h1234_5678, 2,  1, 3'b001, 0};
        vecs[2] = '{32'h2ABC_DEF0, 1'b0, 32'hA5A5_5A5A, 3,  1, 3'b100, 0};
        vecs[3] = '{32'h1FFF_FFFC, 1'b0, 32'h0BAD_BEEF, 1,  1, 3'b010, 0};
        vecs[4] = '{32'h3000_0000, 1'b1, 32'h0,         0,  1, 3'b000, 1};
        vecs[5] = '{32'hF000_0000, 1'b0, 32'h0,         0,  1, 3'b000, 1};
        vecs[6] = '{32'h0000_0040, 1'b0, 32'h600D_CAFE, 16, 1, 3'b001, 0};
        vecs[7] = '{32'h2000_0010, 1'b0, 32'h0,         0,  1, 3'b100, 2};
        vecs[8] = '{32'h0000_0000, 1'b0, 32'h1111_0000, 1,  4, 3'b001, 0};

        #1 wb_rst_n = 1'b0;
        #1;
        checkOutput("rst_cyc", 32'(wbs_cyc_o), 32'h0);
        checkOutput("rst_resp", 32'({wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o}), 32'h0);
        checkOutput("rst_err_adr", err_adr_o, 32'h0);
        repeat (3) @(posedge wb_clk);
        @(negedge wb_clk) wb_rst_n = 1'b1;

        for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

        // Reset in the middle of a stalled BUSY access.
        @(posedge wb_clk); #1;
        wbm_adr_i = 32'h2000_0010; wbm_we_i = 1'b0;
        wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
        driveSlaves(2, 1'b0, 32'h5555_AAAA);
        repeat (4) @(posedge wb_clk);
        #1 checkOutput("pre_reset_busy", 32'(wbs_cyc_o), 32'h4);
        #2 wb_rst_n = 1'b0;
        #1;
        checkOutput("midrst_cyc", 32'(wbs_cyc_o), 32'h0);
        checkOutput("midrst_stb", 32'(wbs_stb_o), 32'h0);
        checkOutput("midrst_adr", wbs_adr_o, 32'h0);
        checkOutput("midrst_resp", 32'({wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o}), 32'h0);
        checkOutput("midrst_sdt", wbm_sdt_o, 32'h0);
        checkOutput("midrst_err_adr", err_adr_o, 32'h0);
        wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
        driveSlaves(2, 1'b0, 32'h0);
        repeat (2) @(posedge wb_clk);
        @(negedge wb_clk) wb_rst_n = 1'b1;
        repeat (3) begin
            @(negedge wb_clk);
            checkOutput("no_resp_after_rst", 32'({wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o}), 32'h0);
        end
        applyStimulus(vecs[0]);

        checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
